// File: rtl/rs_pkg.sv
// Shared defaults, op-code constants and one-hot helpers for the reservation station.
package rs_pkg;

  localparam int RS_DEPTH = 16;
  localparam int RS_NCDB  = 2;
  localparam int RS_RLEN  = 32;
  localparam int RS_ILEN  = 6;
  localparam int RS_RBW   = 4;
  localparam int RS_MAX_N = 64;

  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_SUB = 6'h01;
  localparam logic [5:0] OP_AND = 6'h02;
  localparam logic [5:0] OP_OR  = 6'h03;
  localparam logic [5:0] OP_XOR = 6'h04;
  localparam logic [5:0] OP_SLL = 6'h05;
  localparam logic [5:0] OP_SRL = 6'h06;
  localparam logic [5:0] OP_SLT = 6'h07;

  // OR of set-bit positions; exact for a one-hot (or zero) input.
  function automatic int unsigned onehot_to_idx(input logic [RS_MAX_N-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < RS_MAX_N; i++) begin
      if (oh[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rs_select.sv
// Picks one requester: lowest index, or oldest per age matrix when USE_AGE=1.
// Pure combinational; age[j*N+i]=1 means entry j is older than entry i.
module rs_select
  import rs_pkg::*;
#(
  parameter int N       = 16,
  parameter bit USE_AGE = 1'b0
) (
  input  logic [N-1:0]         req,
  input  logic [N*N-1:0]       age,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_vld
);

  logic [N-1:0]          gnt;
  logic [RS_MAX_N-1:0]   gnt_ext;

  generate
    if (USE_AGE) begin : g_age
      always_comb begin
        for (int i = 0; i < N; i++) begin
          gnt[i] = req[i];
          for (int j = 0; j < N; j++) begin
            if (j != i && req[j] && age[j*N+i]) gnt[i] = 1'b0;
          end
        end
      end
    end else begin : g_low
      logic unused_age;
      assign unused_age = ^age;
      always_comb begin
        gnt = req & (~req + {{(N-1){1'b0}}, 1'b1});
      end
    end
  endgenerate

  always_comb begin
    gnt_ext        = '0;
    gnt_ext[N-1:0] = gnt;
  end

  assign gnt_idx = $clog2(N)'(onehot_to_idx(gnt_ext));
  assign gnt_vld = |req;

endmodule

// File: rtl/rs_multi_cdb.sv
// Reservation station: dispatch with multi-CDB wakeup, one issue per cycle, issue 1 cycle after ready.
// RS_AGE_SELECT_EN: oldest-ready issue via age matrix; otherwise lowest-index ready entry.
module rs_multi_cdb
  import rs_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH,
  parameter int NCDB  = RS_NCDB,
  parameter int RLEN  = RS_RLEN,
  parameter int ILEN  = RS_ILEN,
  parameter int RBW   = RS_RBW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ILEN-1:0]            in_op,
  input  logic [RBW-1:0]             in_rob,
  input  logic                       in_rs1_rdy,
  input  logic                       in_rs2_rdy,
  input  logic [RLEN-1:0]            in_val1,
  input  logic [RLEN-1:0]            in_val2,
  input  logic [RLEN-1:0]            in_imm,
  input  logic                       in_use_imm,
  input  logic [NCDB-1:0]            cdb_valid,
  input  logic [NCDB*RBW-1:0]        cdb_idx,
  input  logic [NCDB*RLEN-1:0]       cdb_val,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [ILEN-1:0]            iss_op,
  output logic [RLEN-1:0]            iss_val1,
  output logic [RLEN-1:0]            iss_val2,
  output logic [RBW-1:0]             iss_rob,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] ent_vld;
  logic [DEPTH-1:0] ent_r1;
  logic [DEPTH-1:0] ent_r2;
  logic [ILEN-1:0]  ent_op  [DEPTH];
  logic [RBW-1:0]   ent_rob [DEPTH];
  logic [RLEN-1:0]  ent_v1  [DEPTH];
  logic [RLEN-1:0]  ent_v2  [DEPTH];

  logic [RLEN:0]    m1 [DEPTH];
  logic [RLEN:0]    m2 [DEPTH];
  logic [RLEN:0]    dm1, dm2;
  logic             new_r1, new_r2;
  logic [RLEN-1:0]  new_v1, new_v2;

  logic [IW-1:0]    free_idx, sel_idx;
  logic             free_vld, sel_vld;
  logic             accept, issue;
  logic [DEPTH-1:0] nxt_vld;
  logic [DEPTH*DEPTH-1:0] sel_age;

  // Returns {hit, value}; iterating downward lets the lowest matching channel win.
  function automatic logic [RLEN:0] cdb_match(
    input logic [RBW-1:0]       tag,
    input logic [NCDB-1:0]      v,
    input logic [NCDB*RBW-1:0]  idx,
    input logic [NCDB*RLEN-1:0] val
  );
    logic [RLEN:0] r;
    r = '0;
    for (int k = NCDB-1; k >= 0; k--) begin
      if (v[k] && idx[k*RBW +: RBW] == tag) r = {1'b1, val[k*RLEN +: RLEN]};
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      m1[i] = cdb_match(ent_v1[i][RBW-1:0], cdb_valid, cdb_idx, cdb_val);
      m2[i] = cdb_match(ent_v2[i][RBW-1:0], cdb_valid, cdb_idx, cdb_val);
    end
  end

  always_comb begin
    dm1    = cdb_match(in_val1[RBW-1:0], cdb_valid, cdb_idx, cdb_val);
    dm2    = cdb_match(in_val2[RBW-1:0], cdb_valid, cdb_idx, cdb_val);
    new_r1 = in_rs1_rdy | dm1[RLEN];
    new_v1 = (!in_rs1_rdy && dm1[RLEN]) ? dm1[RLEN-1:0] : in_val1;
    if (in_use_imm) begin
      new_r2 = 1'b1;
      new_v2 = in_imm;
    end else begin
      new_r2 = in_rs2_rdy | dm2[RLEN];
      new_v2 = (!in_rs2_rdy && dm2[RLEN]) ? dm2[RLEN-1:0] : in_val2;
    end
  end

  rs_select #(.N(DEPTH), .USE_AGE(1'b0)) u_free (
    .req     (~ent_vld),
    .age     ({(DEPTH*DEPTH){1'b0}}),
    .gnt_idx (free_idx),
    .gnt_vld (free_vld)
  );

`ifdef RS_AGE_SELECT_EN
  logic [DEPTH*DEPTH-1:0] age_q;

  // A new entry is younger than every other slot; stale bits of empty slots are masked by req.
  always_ff @(posedge clk) begin
    if (rst) begin
      age_q <= '0;
    end else if (accept) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j != int'(free_idx)) begin
          age_q[j*DEPTH + int'(free_idx)] <= 1'b1;
          age_q[int'(free_idx)*DEPTH + j] <= 1'b0;
        end
      end
    end
  end

  assign sel_age = age_q;

  rs_select #(.N(DEPTH), .USE_AGE(1'b1)) u_issue (
    .req     (ent_vld & ent_r1 & ent_r2),
    .age     (sel_age),
    .gnt_idx (sel_idx),
    .gnt_vld (sel_vld)
  );
`else
  assign sel_age = '0;

  rs_select #(.N(DEPTH), .USE_AGE(1'b0)) u_issue (
    .req     (ent_vld & ent_r1 & ent_r2),
    .age     (sel_age),
    .gnt_idx (sel_idx),
    .gnt_vld (sel_vld)
  );
`endif

  assign in_ready  = rdy & ~rst & (count < CW'(DEPTH));
  assign iss_valid = rdy & sel_vld;
  assign accept    = in_valid & in_ready & ~flush & free_vld;
  assign issue     = iss_valid & iss_ready & ~flush;

  assign iss_op   = ent_op[sel_idx];
  assign iss_rob  = ent_rob[sel_idx];
  assign iss_val1 = ent_v1[sel_idx];
  assign iss_val2 = ent_v2[sel_idx];

  always_comb begin
    nxt_vld = ent_vld;
    if (issue)  nxt_vld[sel_idx]  = 1'b0;
    if (accept) nxt_vld[free_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_vld <= '0;
      count   <= '0;
    end else if (rdy) begin
      if (flush) begin
        ent_vld <= '0;
        count   <= '0;
      end else begin
        ent_vld <= nxt_vld;
        count   <= count + CW'(accept) - CW'(issue);
      end
    end
  end

  // Payload is unreset; validity alone decides whether a slot means anything.
  always_ff @(posedge clk) begin
    if (rdy && !flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_vld[i] && !ent_r1[i] && m1[i][RLEN]) begin
          ent_r1[i] <= 1'b1;
          ent_v1[i] <= m1[i][RLEN-1:0];
        end
        if (ent_vld[i] && !ent_r2[i] && m2[i][RLEN]) begin
          ent_r2[i] <= 1'b1;
          ent_v2[i] <= m2[i][RLEN-1:0];
        end
        if (accept && free_idx == IW'(i)) begin
          ent_op[i]  <= in_op;
          ent_rob[i] <= in_rob;
          ent_r1[i]  <= new_r1;
          ent_v1[i]  <= new_v1;
          ent_r2[i]  <= new_r2;
          ent_v2[i]  <= new_v2;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_multi_cdb.sv
// Directed scenarios plus randomized run against a slot/sequence-number reference model.
module tb_rs_multi_cdb;
  import rs_pkg::*;

  localparam int DEPTH = 16;
  localparam int NCDB  = 2;
  localparam int RLEN  = 32;
  localparam int ILEN  = 6;
  localparam int RBW   = 4;
  localparam int CW    = 5;

  logic                 clk = 1'b0;
  logic                 rst, rdy, flush;
  logic                 in_valid, in_ready, in_rs1_rdy, in_rs2_rdy, in_use_imm;
  logic [ILEN-1:0]      in_op;
  logic [RBW-1:0]       in_rob;
  logic [RLEN-1:0]      in_val1, in_val2, in_imm;
  logic [NCDB-1:0]      cdb_valid;
  logic [NCDB*RBW-1:0]  cdb_idx;
  logic [NCDB*RLEN-1:0] cdb_val;
  logic                 iss_valid, iss_ready;
  logic [ILEN-1:0]      iss_op;
  logic [RLEN-1:0]      iss_val1, iss_val2;
  logic [RBW-1:0]       iss_rob;
  logic [CW-1:0]        count;

  int checks = 0;
  int errors = 0;

  rs_multi_cdb dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rob(in_rob),
    .in_rs1_rdy(in_rs1_rdy), .in_rs2_rdy(in_rs2_rdy),
    .in_val1(in_val1), .in_val2(in_val2), .in_imm(in_imm), .in_use_imm(in_use_imm),
    .cdb_valid(cdb_valid), .cdb_idx(cdb_idx), .cdb_val(cdb_val),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_val1(iss_val1), .iss_val2(iss_val2), .iss_rob(iss_rob), .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; in_use_imm = 1'b0;
    cdb_valid = '0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [3:0] rob,
                      input logic r1, input logic [31:0] v1,
                      input logic r2, input logic [31:0] v2);
    in_valid = 1'b1; in_op = op; in_rob = rob; in_use_imm = 1'b0;
    in_rs1_rdy = r1; in_val1 = v1; in_rs2_rdy = r2; in_val2 = v2;
  endtask

  task automatic bcast(input int k, input logic [3:0] idx, input logic [31:0] val);
    cdb_valid[k] = 1'b1;
    cdb_idx[k*RBW +: RBW] = idx;
    cdb_val[k*RLEN +: RLEN] = val;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  // Lowest valid channel whose tag matches wins.
  function automatic bit cdb_find(input logic [3:0] tag, output logic [31:0] val);
    logic [NCDB*RBW-1:0]  ix;
    logic [NCDB*RLEN-1:0] vv;
    ix  = cdb_idx;
    vv  = cdb_val;
    val = '0;
    for (int k = 0; k < NCDB; k++) begin
      if (cdb_valid[k] && ix[k*RBW +: RBW] == tag) begin
        val = vv[k*RLEN +: RLEN];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic test_reset();
    idle();
    iss_ready = 1'b1; cdb_idx = '0; cdb_val = '0; in_imm = '0;
    rst = 1'b1;
    disp(OP_ADD, 4'd1, 1'b1, 32'd1, 1'b1, 32'd2);
    step();
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    rst = 1'b0;
    idle();
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after got %b want 1", in_ready); end
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL reset_iss_valid got %b want 0", iss_valid); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
  endtask

  task automatic test_basic();
    do_flush();
    iss_ready = 1'b1;
    disp(OP_SUB, 4'd3, 1'b1, 32'd5, 1'b1, 32'd7);
    #1;
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL basic_no_bypass got %b want 0", iss_valid); end
    step();
    idle();
    #1;
    checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL basic_iss_valid got %b want 1", iss_valid); end
    checks++; if ({iss_op, iss_rob, iss_val1, iss_val2} !== {OP_SUB, 4'd3, 32'd5, 32'd7}) begin
      errors++; $display("FAIL basic_fields got op %h rob %0d v1 %0d v2 %0d want op %h rob 3 v1 5 v2 7", iss_op, iss_rob, iss_val1, iss_val2, OP_SUB);
    end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL basic_count1 got %0d want 1", count); end
    step();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL basic_count0 got %0d want 0", count); end
    // Immediate overrides a not-ready rs2 tag.
    disp(OP_ADD, 4'd6, 1'b1, 32'd1, 1'b0, 32'd11);
    in_use_imm = 1'b1; in_imm = 32'h99;
    step();
    idle();
    #1;
    checks++; if (iss_valid !== 1'b1 || iss_val2 !== 32'h99) begin
      errors++; $display("FAIL basic_imm got valid %b v2 %h want 1 99", iss_valid, iss_val2);
    end
    step();
  endtask

  task automatic test_dispatch_wakeup();
    do_flush();
    iss_ready = 1'b1;
    disp(OP_XOR, 4'd2, 1'b0, 32'd9, 1'b1, 32'd1);
    bcast(1, 4'd9, 32'h1234);
    step();
    idle();
    #1;
    checks++; if (iss_valid !== 1'b1 || iss_val1 !== 32'h1234) begin
      errors++; $display("FAIL dwake_ch1 got valid %b v1 %h want 1 1234", iss_valid, iss_val1);
    end
    step();
    disp(OP_XOR, 4'd4, 1'b0, 32'd9, 1'b1, 32'd1);
    bcast(0, 4'd9, 32'hAAAA);
    bcast(1, 4'd9, 32'hBBBB);
    step();
    idle();
    #1;
    checks++; if (iss_valid !== 1'b1 || iss_val1 !== 32'hAAAA) begin
      errors++; $display("FAIL dwake_prio got valid %b v1 %h want 1 aaaa", iss_valid, iss_val1);
    end
    step();
  endtask

  task automatic test_full();
    do_flush();
    iss_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      disp(OP_AND, 4'(i), 1'b0, 32'(i), 1'b1, 32'd0);
      step();
    end
    idle();
    #1;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_count got %0d want 16", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    disp(OP_ADD, 4'd15, 1'b1, 32'd1, 1'b1, 32'd1);
    step();
    idle();
    #1;
    checks++; if (count !== 5'd16 || iss_valid !== 1'b0) begin
      errors++; $display("FAIL full_17th got count %0d valid %b want 16 0", count, iss_valid);
    end
    bcast(0, 4'd5, 32'h55);
    step();
    idle();
    #1;
    checks++; if (iss_valid !== 1'b1 || iss_rob !== 4'd5 || iss_val1 !== 32'h55) begin
      errors++; $display("FAIL full_wake5 got valid %b rob %0d v1 %h want 1 5 55", iss_valid, iss_rob, iss_val1);
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready_pre got %b want 0", in_ready); end
    step();
    checks++; if (count !== 5'd15 || in_ready !== 1'b1) begin
      errors++; $display("FAIL full_after_issue got count %0d in_ready %b want 15 1", count, in_ready);
    end
    do_flush();
  endtask

  task automatic test_age_order();
    logic [3:0] first_rob, second_rob;
`ifdef RS_AGE_SELECT_EN
    first_rob = 4'd2; second_rob = 4'd3;
`else
    first_rob = 4'd3; second_rob = 4'd2;
`endif
    do_flush();
    iss_ready = 1'b0;
    disp(OP_ADD, 4'd1, 1'b1, 32'd10, 1'b1, 32'd11);
    step();
    disp(OP_ADD, 4'd2, 1'b0, 32'd7, 1'b1, 32'd21);
    step();
    idle();
    iss_ready = 1'b1;
    #1;
    checks++; if (iss_rob !== 4'd1) begin errors++; $display("FAIL age_a got rob %0d want 1", iss_rob); end
    step();
    iss_ready = 1'b0;
    disp(OP_ADD, 4'd3, 1'b1, 32'd30, 1'b1, 32'd31);
    bcast(1, 4'd7, 32'h77);
    step();
    idle();
    #1;
    checks++; if (iss_valid !== 1'b1 || iss_rob !== first_rob) begin
      errors++; $display("FAIL age_first got valid %b rob %0d want 1 %0d", iss_valid, iss_rob, first_rob);
    end
    iss_ready = 1'b1;
    step();
    checks++; if (iss_valid !== 1'b1 || iss_rob !== second_rob) begin
      errors++; $display("FAIL age_second got valid %b rob %0d want 1 %0d", iss_valid, iss_rob, second_rob);
    end
    step();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL age_drain got %0d want 0", count); end
  endtask

  task automatic test_flush();
    do_flush();
    iss_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(OP_OR, 4'(i), 1'b1, 32'(i), 1'b1, 32'd0);
      step();
    end
    idle();
    #1;
    checks++; if (count !== 5'd4) begin errors++; $display("FAIL flush_pre got %0d want 4", count); end
    flush = 1'b1;
    iss_ready = 1'b1;
    disp(OP_OR, 4'd9, 1'b1, 32'd9, 1'b1, 32'd9);
    bcast(0, 4'd1, 32'h5);
    step();
    idle();
    #1;
    checks++; if (count !== 5'd0 || iss_valid !== 1'b0) begin
      errors++; $display("FAIL flush_post got count %0d valid %b want 0 0", count, iss_valid);
    end
  endtask

  task automatic test_stall();
    do_flush();
    iss_ready = 1'b0;
    disp(OP_SLT, 4'd1, 1'b1, 32'd1, 1'b1, 32'd2);
    step();
    disp(OP_SLT, 4'd2, 1'b0, 32'd4, 1'b1, 32'd2);
    step();
    idle();
    rdy = 1'b0;
    iss_ready = 1'b1;
    disp(OP_SLT, 4'd6, 1'b1, 32'd6, 1'b1, 32'd6);
    bcast(0, 4'd4, 32'h44);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (count !== 5'd2 || iss_valid !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_c%0d got count %0d valid %b in_ready %b want 2 0 0", c, count, iss_valid, in_ready);
      end
    end
    idle();
    iss_ready = 1'b0;
    #1;
    checks++; if (iss_valid !== 1'b1 || iss_rob !== 4'd1) begin
      errors++; $display("FAIL stall_resume got valid %b rob %0d want 1 1", iss_valid, iss_rob);
    end
    iss_ready = 1'b1;
    step();
    checks++; if (count !== 5'd1 || iss_valid !== 1'b0) begin
      errors++; $display("FAIL stall_no_wake got count %0d valid %b want 1 0", count, iss_valid);
    end
    do_flush();
  endtask

  task automatic test_random();
    bit          m_vld [DEPTH];
    bit          m_r1  [DEPTH];
    bit          m_r2  [DEPTH];
    logic [5:0]  m_op  [DEPTH];
    logic [3:0]  m_rob [DEPTH];
    logic [31:0] m_v1  [DEPTH];
    logic [31:0] m_v2  [DEPTH];
    int          m_seq [DEPTH];
    int          m_cnt, seqn, sel, slot;
    bit          e_ready, e_iss, hit;
    logic [31:0] hv;
    m_cnt = 0; seqn = 0;
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rdy        = ($urandom_range(0, 9) != 0);
      flush      = ($urandom_range(0, 59) == 0);
      in_valid   = ($urandom_range(0, 1) == 1);
      in_op      = 6'($urandom);
      in_rob     = 4'($urandom);
      in_rs1_rdy = ($urandom_range(0, 2) == 0);
      in_rs2_rdy = ($urandom_range(0, 2) != 0);
      in_val1    = $urandom;
      in_val2    = $urandom;
      in_imm     = $urandom;
      in_use_imm = ($urandom_range(0, 3) == 0);
      iss_ready  = ($urandom_range(0, 3) < ((cyc % 1000) < 500 ? 1 : 3));
      for (int k = 0; k < NCDB; k++) begin
        cdb_valid[k] = ($urandom_range(0, 1) == 1);
        cdb_idx[k*RBW +: RBW] = 4'($urandom_range(0, 15));
        cdb_val[k*RLEN +: RLEN] = $urandom;
      end
      #1;
      e_ready = rdy && (m_cnt < DEPTH);
      sel = -1;
      for (int i = 0; i < DEPTH; i++) begin
        if (m_vld[i] && m_r1[i] && m_r2[i]) begin
`ifdef RS_AGE_SELECT_EN
          if (sel < 0 || m_seq[i] < m_seq[sel]) sel = i;
`else
          if (sel < 0) sel = i;
`endif
        end
      end
      e_iss = rdy && (sel >= 0);
      checks++; if (in_ready !== e_ready) begin errors++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", cyc, in_ready, e_ready); end
      checks++; if (iss_valid !== e_iss) begin errors++; $display("FAIL rnd_iss_valid cyc %0d got %b want %b", cyc, iss_valid, e_iss); end
      checks++; if (count !== CW'(m_cnt)) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", cyc, count, m_cnt); end
      if (e_iss) begin
        checks++;
        if ({iss_op, iss_rob, iss_val1, iss_val2} !== {m_op[sel], m_rob[sel], m_v1[sel], m_v2[sel]}) begin
          errors++;
          $display("FAIL rnd_iss_fields cyc %0d got %h/%0d/%h/%h want %h/%0d/%h/%h", cyc,
                   iss_op, iss_rob, iss_val1, iss_val2, m_op[sel], m_rob[sel], m_v1[sel], m_v2[sel]);
        end
      end
      if (rdy) begin
        if (flush) begin
          for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
          m_cnt = 0;
        end else begin
          slot = -1;
          for (int i = DEPTH-1; i >= 0; i--) if (!m_vld[i]) slot = i;
          for (int i = 0; i < DEPTH; i++) begin
            if (m_vld[i] && !m_r1[i]) begin
              hit = cdb_find(m_v1[i][3:0], hv);
              if (hit) begin m_r1[i] = 1'b1; m_v1[i] = hv; end
            end
            if (m_vld[i] && !m_r2[i]) begin
              hit = cdb_find(m_v2[i][3:0], hv);
              if (hit) begin m_r2[i] = 1'b1; m_v2[i] = hv; end
            end
          end
          if (e_iss && iss_ready) begin
            m_vld[sel] = 1'b0;
            m_cnt--;
          end
          if (in_valid && e_ready && slot >= 0) begin
            m_vld[slot] = 1'b1; m_op[slot] = in_op; m_rob[slot] = in_rob;
            m_r1[slot] = in_rs1_rdy; m_v1[slot] = in_val1;
            if (!in_rs1_rdy) begin
              hit = cdb_find(in_val1[3:0], hv);
              if (hit) begin m_r1[slot] = 1'b1; m_v1[slot] = hv; end
            end
            if (in_use_imm) begin
              m_r2[slot] = 1'b1; m_v2[slot] = in_imm;
            end else begin
              m_r2[slot] = in_rs2_rdy; m_v2[slot] = in_val2;
              if (!in_rs2_rdy) begin
                hit = cdb_find(in_val2[3:0], hv);
                if (hit) begin m_r2[slot] = 1'b1; m_v2[slot] = hv; end
              end
            end
            m_seq[slot] = seqn;
            seqn++;
            m_cnt++;
          end
        end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dispatch_wakeup();
    test_full();
    test_age_order();
    test_flush();
    test_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_multi_cdb.md
RS_MULTI_CDB -- requirements
Module: rs_multi_cdb

Interface
REQ-001 SHALL have parameter DEPTH, 16, number of entries (power of two, >=2).
REQ-002 SHALL have parameter NCDB, 2, number of result broadcast channels.
REQ-003 SHALL have parameter RLEN, 32, operand/result width.
REQ-004 SHALL have parameter ILEN, 6, internal op-code width.
REQ-005 SHALL have parameter RBW, 4, ROB index width.
REQ-006 SHALL have port clk input 1: clock; rst input 1: reset, synchronous, active-high.
REQ-007 SHALL have port rdy input 1: global enable; low = stall.
REQ-008 SHALL have port flush input 1: branch mispredict, discard all entries.
REQ-009 SHALL have ports in_valid input 1 and in_ready output 1: dispatch handshake.
REQ-010 SHALL have ports in_op input ILEN and in_rob input RBW: op code and destination ROB index.
REQ-011 SHALL have ports in_rs1_rdy and in_rs2_rdy input 1: operand holds a value (1) or a ROB tag in bits [RBW-1:0] (0).
REQ-012 SHALL have ports in_val1, in_val2, in_imm input RLEN, and in_use_imm input 1: select in_imm as operand 2.
REQ-013 SHALL have ports cdb_valid input NCDB, cdb_idx input NCDB*RBW, cdb_val input NCDB*RLEN: channel k at slice k.
REQ-014 SHALL have ports iss_valid output 1 and iss_ready input 1: issue handshake to ALU.
REQ-015 SHALL have ports iss_op output ILEN, iss_val1 and iss_val2 output RLEN, iss_rob output RBW.
REQ-016 SHALL have port count output clog2(DEPTH+1): occupied entries.

Function
REQ-017 SHALL set in_ready = rdy & (count < DEPTH), driven from registered occupancy only.
REQ-018 SHALL accept dispatch when in_valid & in_ready & !flush, writing into the lowest-index free slot.
REQ-019 SHALL set operand 2 to in_imm and mark it ready when in_use_imm=1.
REQ-020 SHALL capture a not-ready dispatch operand from any cdb channel whose tag matches in the dispatch cycle; the lowest channel wins on multiple matches.
REQ-021 SHALL, at each edge with rdy=1, update every stored not-ready operand whose tag matches a valid channel (lowest channel wins) and mark it ready.
REQ-022 SHALL register all entry fields; an entry becomes issue-eligible no earlier than the cycle after dispatch or wakeup (no same-cycle bypass to issue).
REQ-023 SHALL drive iss_valid = rdy & (any entry with both operands ready); iss_* fields are combinational from the selected entry.
REQ-024 SHALL free the selected slot at the edge when iss_valid & iss_ready; a freed slot is reusable from the next cycle.
REQ-025 SHALL hold iss_* stable while iss_valid=1 & iss_ready=0, unless a higher-priority entry becomes eligible.
REQ-026 SHALL update count by +accept -issue in the same edge; a simultaneous accept and issue leaves it unchanged.
REQ-027 SHALL, when flush=1 with rdy=1, clear all entries and count, drop same-cycle dispatch, issue and wakeup.
REQ-028 SHALL, when rdy=0, hold all state; cdb inputs are ignored.

Reset
REQ-029 SHALL, on rst, clear all valid bits, age state and count; outputs read in_ready=0 during rst, then iss_valid=0, count=0; payload registers are not reset.
REQ-030 SHALL give rst priority over flush, dispatch and issue.

Configuration
REQ-031 SHALL, with RS_AGE_SELECT_EN defined, select the oldest ready entry using a DEPTH x DEPTH age matrix updated on dispatch.
REQ-032 SHALL, without RS_AGE_SELECT_EN, select the lowest-index ready entry and contain no age state.

Structure
REQ-033 SHALL take default parameter values, op-code constants and the one-hot-to-index function from the shared package rs_pkg.
REQ-034 SHALL implement selection in sub-module rs_select (ready mask in, grant index and valid out, age mode per macro); free-slot search reuses it in lowest-index mode.

Verification
REQ-035 SHALL cover: dispatch op with val1=5, val2=7, both ready, rob=3, iss_ready=1 -> next cycle iss_valid=1, values 5/7, rob 3; count 1 then 0.
REQ-036 SHALL cover: dispatch rs1 tag 9 while cdb ch1 broadcasts idx 9, val 0x1234 -> next cycle issue with iss_val1=0x1234.
REQ-037 SHALL cover: 16 non-ready dispatches -> count=16, in_ready=0, 17th ignored; wake slot 5 -> it issues, in_ready=1 the cycle after.
REQ-038 SHALL cover: A ready in slot 0, B waiting in slot 1; A issues; C ready in slot 0; wake B -> with macro B issues before C, without macro C issues first.
REQ-039 SHALL cover: flush with concurrent dispatch, issue and broadcast at count=4 -> next cycle count=0, iss_valid=0.
REQ-040 SHALL cover: rdy=0 for 3 cycles with in_valid and broadcasts -> count and entries unchanged, iss_valid=0.
